// File: rtl/simple_processor_pkg.sv
// Shared processor definitions: datapath width and the ALU function encoding.
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;

  // Only ADD, SUB, ADDI and MUL are executed by the math ALU; the remaining
  // encodings belong to other units and are reported as illegal here.
  typedef enum logic [2:0] {
    FUNC_ADD  = 3'd0,
    FUNC_SUB  = 3'd1,
    FUNC_ADDI = 3'd2,
    FUNC_MUL  = 3'd3,
    FUNC_AND  = 3'd4,
    FUNC_OR   = 3'd5
  } func_t;

endpackage

// File: rtl/alu_math_mul_iter.sv
// Radix-2 shift-add multiplier: one partial product per cycle, DATA_WIDTH
// cycles per operation. product_o is valid in the cycle done_o is high.
module alu_math_mul_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic                  busy_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_next;

  // Only low DATA_WIDTH bits are kept, so the signed/unsigned distinction vanishes.
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == CNT_LAST);
  assign product_o = acc_next;

  // Iteration control: busy flag and step counter, cleared by reset to abort.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

  // Datapath: shift multiplicand left, multiplier right, accumulate.
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next;
    end
  end

endmodule

// File: rtl/alu_math_mc.sv
// Multi-cycle handshaked ALU math path: ADD, SUB, ADDI in one cycle, optional
// iterative MUL when ALU_MATH_MUL_EN is defined (otherwise MUL is illegal).
module alu_math_mc
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int IMM_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  func_t                 func_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [IMM_WIDTH-1:0]  imm_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  illegal_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic                  handshake;
  logic                  legal;
  logic                  is_mul;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  carry_in;
  logic [DATA_WIDTH-1:0] sum;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  illegal_q;

  function automatic logic [DATA_WIDTH-1:0] sign_ext(input logic signed [IMM_WIDTH-1:0] v);
    return {{(DATA_WIDTH-IMM_WIDTH){v[IMM_WIDTH-1]}}, v};
  endfunction

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign handshake   = req_valid_i && req_ready_o;
  assign result_o    = result_q;
  assign illegal_o   = illegal_q;

  // Decode: select the shared adder's second operand and carry-in.
  always_comb begin
    op_b     = rs2_data_i;
    carry_in = 1'b0;
    legal    = 1'b1;
    is_mul   = 1'b0;
    case (func_i)
      FUNC_ADD:  ;
      FUNC_SUB: begin
        op_b     = ~rs2_data_i;
        carry_in = 1'b1;
      end
      FUNC_ADDI: op_b = sign_ext(imm_i);
`ifdef ALU_MATH_MUL_EN
      FUNC_MUL:  is_mul = 1'b1;
`endif
      default:   legal = 1'b0;
    endcase
  end

  assign sum = rs1_data_i + op_b + {{(DATA_WIDTH-1){1'b0}}, carry_in};

`ifdef ALU_MATH_MUL_EN
  alu_math_mul_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .start_i   (handshake && is_mul),
    .a_i       (rs1_data_i),
    .b_i       (rs2_data_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`else
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // State register; reset abandons any in-flight or pending operation.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (handshake) state_d = is_mul ? CALC : DONE;
      CALC: if (mul_done) state_d = DONE;
      DONE: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result register: loaded at handshake (single-cycle ops) or at MUL completion.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (handshake && !is_mul) begin
      result_q  <= legal ? sum : '0;
      illegal_q <= !legal;
    end else if ((state_q == CALC) && mul_done) begin
      result_q  <= mul_product;
      illegal_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_math_mc.sv
// Scoreboard bench for alu_math_mc: driver pushes expected responses, a
// separate monitor pops and compares whenever a response is accepted.
module tb_alu_math_mc;
  import simple_processor_pkg::*;

  logic        clk = 1'b0;
  logic        arst_ni;
  logic        req_valid;
  logic        req_ready;
  func_t       func;
  logic [31:0] rs1, rs2;
  logic [5:0]  imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          hs;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_math_mc #(.DATA_WIDTH(32), .IMM_WIDTH(6)) dut (
    .clk_i       (clk),
    .arst_ni     (arst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .func_i      (func),
    .rs1_data_i  (rs1),
    .rs2_data_i  (rs2),
    .imm_i       (imm),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .result_o    (result),
    .illegal_o   (illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a request until it is accepted; optionally record its expected response.
  task automatic issue(input func_t f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] im, input bit push, input logic [31:0] eres,
                       input bit eill, input int elat);
    bit ok = 1'b0;
    int hs = 0;
    func = f; rs1 = a; rs2 = b; imm = im; req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready) begin
        hs = cyc;
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    rs1 = 32'hDEAD_BEEF; rs2 = 32'hCAFE_F00D; imm = 6'h2A; func = FUNC_OR;
    if (!ok) check("issue_timeout", 32'd0, 32'd1);
    else if (push) q.push_back('{eres, eill, hs, elat});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    check("drain", q.size(), 32'd0);
    q.delete();
    @(posedge clk); #1;
  endtask

  // Monitor: latency at first sight of a response, value at acceptance.
  initial begin
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && !prev && q.size() > 0)
        check("latency", cyc - q[0].hs, q[0].lat);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rsp: got result 0x%08h illegal %0b, expected no response", result, illegal);
        end else begin
          e = q.pop_front();
          check("result", result, e.res);
          check("illegal", 32'(illegal), 32'(e.ill));
        end
      end
      prev = rsp_valid;
    end
  end

  initial begin
    arst_ni = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    func = FUNC_ADD; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    arst_ni = 1'b1;
    @(posedge clk); #1;

    issue(FUNC_ADD,  32'hFFFF_FFFF, 32'h1, 6'h0,  1, 32'h0,         0, 1);
    issue(FUNC_SUB,  32'd5,         32'd7, 6'h0,  1, 32'hFFFF_FFFE, 0, 1);
    issue(FUNC_ADDI, 32'd10,        32'h55, 6'h3F, 1, 32'd9,        0, 1);
    issue(FUNC_ADDI, 32'd10,        32'h55, 6'h1F, 1, 32'd41,       0, 1);
    issue(FUNC_ADDI, 32'h7FFF_FFFF, 32'h0, 6'h20, 1, 32'h7FFF_FFDF, 0, 1);
    issue(FUNC_SUB,  32'h8000_0000, 32'h1, 6'h0,  1, 32'h7FFF_FFFF, 0, 1);
    issue(FUNC_AND,  32'd3,         32'd4, 6'h0,  1, 32'h0,         1, 1);
    wait_drain();

    // Backpressure: result held, no new request accepted, stray request ignored.
    rsp_ready = 1'b0;
    issue(FUNC_ADD, 32'd3, 32'd4, 6'h0, 1, 32'd7, 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result",    result,         32'd7);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      if (i == 1) begin
        func = FUNC_SUB; rs1 = 32'd9; rs2 = 32'd2; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();
    check("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);

`ifdef ALU_MATH_MUL_EN
    issue(FUNC_MUL, 32'h1234,      32'h10,        6'h0, 1, 32'h0001_2340, 0, 33);
    issue(FUNC_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h0, 1, 32'h0000_0001, 0, 33);
    issue(FUNC_MUL, 32'h0000_ABCD, 32'hFFFF_FFFF, 6'h0, 1, 32'hFFFF_5433, 0, 33);
`else
    issue(FUNC_MUL, 32'h1234,      32'h10,        6'h0, 1, 32'h0,         1, 1);
`endif
    wait_drain();

    // Reset during a multiply: nothing delivered, block returns to IDLE.
    rsp_ready = 1'b0;
    issue(FUNC_MUL, 32'h1234, 32'h10, 6'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 9; i++) begin
`ifdef ALU_MATH_MUL_EN
      check("calc_rsp_valid", 32'(rsp_valid), 32'd0);
`endif
      @(posedge clk); #1;
    end
    #2 arst_ni = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_result",    result,         32'd0);
    check("arst_illegal",   32'(illegal),   32'd0);
    repeat (2) @(posedge clk);
    #1 arst_ni = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    issue(FUNC_ADD, 32'd1, 32'd1, 6'h0, 1, 32'd2, 0, 1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
